digit_scan_ctrl: RTL and testbench

- Upstream driver for the 3-to-8 digit-select decoder. Its `sel` output feeds the decoder's 3-bit select input.
- Holds eight 4-bit digit values in a small register file and time-multiplexes them. A prescaled dwell counter steps the scan index through the digits enabled in a mask.
- Presents the current digit value and a blank flag to the segment encoder.

---
 rtl/digit_scan_ctrl.sv | 82 ++++++++
 tb/tb_digit_scan_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_ctrl.sv
// Digit scan controller: prescaled dwell counter stepping a select index
// through the mask-enabled digits of an 8 x 4-bit register file.
module digit_scan_ctrl #(
    parameter int unsigned DIV = 50000,
    parameter int unsigned CW  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic [7:0] mask,
    output logic [2:0] sel,
    output logic [3:0] digit,
    output logic       blank,
    output logic       tick
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    sel_q, sel_d;
    logic          tick_q, tick_d;
    logic [3:0]    dig_q [8];
    logic          adv;
    logic [2:0]    nxt;
    logic [2:0]    idx;

    assign adv = en && (cnt_q == CW'(DIV - 1));

    // Walk the rotate order downwards so the nearest enabled index wins.
    always_comb begin
        nxt = sel_q;
        idx = sel_q;
        for (int k = 8; k >= 1; k--) begin
            idx = sel_q + 3'(k);
            if (mask[idx]) begin
                nxt = idx;
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        sel_d  = sel_q;
        tick_d = 1'b0;
        if (en) begin
            cnt_d = adv ? '0 : cnt_q + 1'b1;
        end
        if (adv && (mask != 8'h00)) begin
            sel_d  = nxt;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sel_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sel_q  <= sel_d;
            tick_q <= tick_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                dig_q[i] <= 4'h0;
            end
        end else if (wr_en) begin
            dig_q[wr_addr] <= wr_data;
        end
    end

    assign sel   = sel_q;
    assign tick  = tick_q;
    assign digit = dig_q[sel_q];
    assign blank = ~en | ~mask[sel_q];

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Randomised bench for digit_scan_ctrl checked against a cycle-level
// behavioural model of dwell, rotate search and the digit store.
module tb_digit_scan_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [7:0] mask;
    logic [2:0] sel;
    logic [3:0] digit;
    logic       blank;
    logic       tick;

    int n_chk = 0;
    int n_err = 0;

    int m_cnt;
    int m_sel;
    int m_tick;
    int m_dig [8];

    always #5 clk = ~clk;

    digit_scan_ctrl #(.DIV(DIV), .CW(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .mask    (mask),
        .sel     (sel),
        .digit   (digit),
        .blank   (blank),
        .tick    (tick)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_sel  = 0;
        m_tick = 0;
        for (int i = 0; i < 8; i++) m_dig[i] = 0;
    endtask

    // One rising edge worth of behaviour, from the current inputs.
    task automatic model_edge();
        m_tick = 0;
        if (en) begin
            m_cnt++;
            if (m_cnt == DIV) begin
                m_cnt = 0;
                if (mask != 8'h00) begin
                    for (int k = 1; k <= 8; k++) begin
                        if (mask[(m_sel + k) % 8]) begin
                            m_sel = (m_sel + k) % 8;
                            break;
                        end
                    end
                    m_tick = 1;
                end
            end
        end
        if (wr_en) m_dig[wr_addr] = wr_data;
    endtask

    task automatic check_outputs();
        chk("sel", sel, m_sel);
        chk("digit", digit, m_dig[m_sel]);
        chk("blank", blank, (!en || !mask[m_sel]) ? 1 : 0);
        chk("tick", tick, m_tick);
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic run(input int n);
        repeat (n) begin
            #1 check_outputs();
            @(posedge clk);
            model_edge();
            @(negedge clk);
            wr_en = 1'b0;
        end
    endtask

    task automatic reset_mid();
        #3 rst = 1'b1;
        #1;
        chk("rst_sel", sel, 0);
        chk("rst_digit", digit, 0);
        chk("rst_tick", tick, 0);
        chk("rst_blank", blank, (!en || !mask[0]) ? 1 : 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        en = 1'b1;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        mask = 8'hFF;
        model_reset();
        #2;
        chk("init_sel", sel, 0);
        chk("init_digit", digit, 0);
        chk("init_tick", tick, 0);
        chk("init_blank", blank, 0);
        @(negedge clk);
        rst = 1'b0;

        run(40);

        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            wr_addr = 3'(i);
            wr_data = 4'(i + 3);
            run(1);
        end
        run(36);
        wr_en = 1'b1;
        wr_addr = sel;
        wr_data = 4'hE;
        run(2);

        mask = 8'b1000_0101;
        run(24);

        mask = 8'h00;
        run(12);
        mask = 8'h10;
        run(8);

        mask = 8'hFF;
        run(9);
        mask = 8'hFF & ~(8'h01 << m_sel);
        run(1);
        en = 1'b0;
        run(3);
        en = 1'b1;
        mask = 8'hFF;
        run(8);

        guard = 0;
        while (m_sel != 5 && guard < 100) begin
            run(1);
            guard++;
        end
        chk("reach_sel5", m_sel, 5);
        run(1);
        reset_mid();
        run(12);

        for (int c = 0; c < 1500; c++) begin
            en = ($urandom_range(0, 7) != 0);
            wr_en = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 31))
                0: mask = 8'($urandom);
                1: mask = 8'h00;
                2: mask = 8'h01 << $urandom_range(0, 7);
                default: ;
            endcase
            if ($urandom_range(0, 499) == 0) begin
                reset_mid();
            end else begin
                run(1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
